usb_out_txn_sequencer: RTL and testbench



---
 rtl/usb_out_txn_sequencer.sv | 159 +++++++++++++++
 tb/tb_usb_out_txn_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_out_txn_sequencer.sv
// Host-side USB OUT transaction sequencer: OUT token, DATA0 payload, then waits
// for the device handshake, retrying on NAK or timeout up to MAX_RETRY times.
module usb_out_txn_sequencer #(
  parameter int IPG_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 8,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [6:0]    req_addr,
  input  logic [3:0]    req_endp,
  input  logic [63:0]   req_data,
  output logic          pkt_avail,
  output logic [7:0]    pid_out,
  output logic [6:0]    addr_out,
  output logic [3:0]    endp_out,
  output logic [63:0]   data_out,
  input  logic          tx_stall,
  input  logic          tx_last,
  input  logic          rx_valid,
  input  logic [7:0]    rx_pid,
  output logic          done,
  output logic          status,
  output logic [RW-1:0] retries
);

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  localparam int GW = $clog2(IPG_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(IPG_CYCLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IPG_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, SEND_TOK, WAIT_TOK, GAP, SEND_DATA, WAIT_DATA, WAIT_HS, DONE
  } state_t;

  state_t        state_q;
  logic          next_data_q;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          pkt_avail_q, done_q, status_q;
  logic [7:0]    pid_q;
  logic [6:0]    addr_q;
  logic [3:0]    endp_q;
  logic [63:0]   data_q;
  logic [RW-1:0] retries_q;
  logic          tx_done, hs_ack, hs_fail;

  // Both counters saturate so a long stay can never wrap into a false match.
  // NOTE: always_comb outputs are fully assigned on every path, so no latch is inferred.
  always_comb begin
    gap_cnt_d = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
    to_cnt_d  = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
  end

  assign tx_done = tx_last && !tx_stall;
  assign hs_ack  = rx_valid && (rx_pid == PID_ACK);
  assign hs_fail = (rx_valid && (rx_pid == PID_NAK)) || (to_cnt_d == TO_MAX);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched request fields are plain registers, cleared so outputs read 0 after reset.
      state_q     <= IDLE;
      next_data_q <= 1'b0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
      pkt_avail_q <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 1'b0;
      pid_q       <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      data_q      <= '0;
      retries_q   <= '0;
    end else begin
      pkt_avail_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q      <= req_addr;
          endp_q      <= req_endp;
          data_q      <= req_data;
          retries_q   <= '0;
          pkt_avail_q <= 1'b1;
          pid_q       <= PID_OUT;
          state_q     <= SEND_TOK;
        end
        SEND_TOK: state_q <= WAIT_TOK;
        WAIT_TOK: if (tx_done) begin
          next_data_q <= 1'b1;
          gap_cnt_q   <= '0;
          state_q     <= GAP;
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            pkt_avail_q <= 1'b1;
            if (next_data_q) begin
              pid_q   <= PID_DATA0;
              state_q <= SEND_DATA;
            end else begin
              pid_q   <= PID_OUT;
              state_q <= SEND_TOK;
            end
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        SEND_DATA: state_q <= WAIT_DATA;
        WAIT_DATA: if (tx_done) begin
          to_cnt_q <= '0;
          state_q  <= WAIT_HS;
        end
        WAIT_HS: begin
          to_cnt_q <= to_cnt_d;
          // ACK is tested first so it beats a timeout landing in the same cycle.
          if (hs_ack) begin
            done_q   <= 1'b1;
            status_q <= 1'b0;
            state_q  <= DONE;
          end else if (hs_fail) begin
            if (retries_q == RETRY_MAX) begin
              done_q   <= 1'b1;
              status_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              retries_q   <= retries_q + 1'b1;
              next_data_q <= 1'b0;
              gap_cnt_q   <= '0;
              state_q     <= GAP;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign pkt_avail = pkt_avail_q;
  assign pid_out   = pid_q;
  assign addr_out  = addr_q;
  assign endp_out  = endp_q;
  assign data_out  = data_q;
  assign done      = done_q;
  assign status    = status_q;
  assign retries   = retries_q;

endmodule

// File: tb/tb_usb_out_txn_sequencer.sv
// Scoreboard bench for usb_out_txn_sequencer: stimulus queues expected launches
// and completions with their cycle; a negedge monitor pops and compares them.
module tb_usb_out_txn_sequencer;

  localparam int IPG_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int MAX_RETRY      = 2;
  localparam int RW             = $clog2(MAX_RETRY + 1);

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [6:0]    req_addr, addr_out;
  logic [3:0]    req_endp, endp_out;
  logic [63:0]   req_data, data_out;
  logic          pkt_avail;
  logic [7:0]    pid_out;
  logic          tx_stall, tx_last;
  logic          rx_valid;
  logic [7:0]    rx_pid;
  logic          done, status;
  logic [RW-1:0] retries;

  usb_out_txn_sequencer #(
    .IPG_CYCLES(IPG_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data),
    .pkt_avail(pkt_avail), .pid_out(pid_out),
    .addr_out(addr_out), .endp_out(endp_out), .data_out(data_out),
    .tx_stall(tx_stall), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_pid(rx_pid),
    .done(done), .status(status), .retries(retries)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_done;
    logic [7:0]    pid;
    bit            status;
    logic [RW-1:0] retries;
    int            at;
    logic [6:0]    addr;
    logic [3:0]    endp;
    logic [63:0]   data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [6:0]  cur_addr;
  logic [3:0]  cur_endp;
  logic [63:0] cur_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit is_done, input logic [7:0] pid, input bit st,
                          input logic [RW-1:0] rt, input int at);
    exp_t e;
    e.is_done = is_done; e.pid = pid; e.status = st; e.retries = rt; e.at = at;
    e.addr = cur_addr; e.endp = cur_endp; e.data = cur_data;
    sb.push_back(e);
  endtask

  // Monitor: every pkt_avail/done must match the oldest expectation, in the expected cycle.
  always @(negedge clk) begin
    if (pkt_avail === 1'b1 || done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {62'd0, pkt_avail, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_kind", {62'd0, pkt_avail, done}, e.is_done ? 64'd1 : 64'd2);
        check("out_cycle", 64'(cyc), 64'(e.at));
        if (e.is_done) begin
          check("done_status", 64'(status), 64'(e.status));
          check("done_retries", 64'(retries), 64'(e.retries));
        end else begin
          check("pkt_pid", 64'(pid_out), 64'(e.pid));
        end
        check("addr_out", 64'(addr_out), 64'(e.addr));
        check("endp_out", 64'(endp_out), 64'(e.endp));
        check("data_out", data_out, e.data);
      end
    end else if (sb.size() != 0 && sb[0].at < cyc) begin
      check("missing_output", {62'd0, pkt_avail, done}, sb[0].is_done ? 64'd1 : 64'd2);
      void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic request(input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    cur_addr = a; cur_endp = e; cur_data = d;
    req_addr = a; req_endp = e; req_data = d; req_valid = 1'b1;
    push_exp(1'b0, PID_OUT, 1'b0, '0, cyc + 1);
    tick();
    req_valid = 1'b0;
    req_addr = ~a; req_endp = ~e; req_data = ~d;
    check("req_ready_busy", 64'(req_ready), 64'd0);
  endtask

  // tx_last held through `stalls` stalled cycles, then one completing cycle.
  task automatic send_last(input int stalls, input bit expect_data);
    for (int i = 0; i < stalls; i++) begin
      tx_last = 1'b1; tx_stall = 1'b1;
      tick();
    end
    tx_stall = 1'b0; tx_last = 1'b1;
    if (expect_data) push_exp(1'b0, PID_DATA0, 1'b0, '0, cyc + 1 + IPG_CYCLES);
    tick();
    tx_last = 1'b0;
  endtask

  task automatic handshake(input logic [7:0] pid);
    rx_valid = 1'b1; rx_pid = pid;
    tick();
    rx_valid = 1'b0; rx_pid = 8'h00;
  endtask

  initial begin
    int d;
    rst = 1'b1; req_valid = 1'b1; req_addr = 7'h55; req_endp = 4'hA; req_data = '1;
    tx_stall = 1'b0; tx_last = 1'b1; rx_valid = 1'b1; rx_pid = PID_ACK;
    cur_addr = '0; cur_endp = '0; cur_data = '0;

    // Reset dominates live request/handshake inputs.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_pkt_avail", 64'(pkt_avail), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_status", 64'(status), 64'd0);
      check("rst_retries", 64'(retries), 64'd0);
      check("rst_pid", 64'(pid_out), 64'd0);
      check("rst_addr_endp", {53'd0, addr_out, endp_out}, 64'd0);
      check("rst_data", data_out, 64'd0);
    end
    rst = 1'b0; req_valid = 1'b0; tx_last = 1'b0; rx_valid = 1'b0; rx_pid = 8'h00;
    tick();

    // Happy path.
    request(7'd5, 4'd4, 64'hCAFEBABEDEADBEEF);
    repeat (32) tick();
    send_last(0, 1'b1);
    repeat (96) tick();
    send_last(0, 1'b0);
    repeat (9) tick();
    push_exp(1'b1, 8'h00, 1'b0, 2'd0, cyc + 1);
    handshake(PID_ACK);
    drain(20);

    // Stalled tx_last in both wait states.
    request(7'h2A, 4'h3, 64'h0011223344556677);
    repeat (5) tick();
    send_last(5, 1'b1);
    repeat (6) tick();
    send_last(3, 1'b0);
    repeat (2) tick();
    push_exp(1'b1, 8'h00, 1'b0, 2'd0, cyc + 1);
    handshake(PID_ACK);
    drain(20);

    // NAK, NAK, ACK; stray ACK in GAP and a foreign PID in WAIT_HS are ignored.
    request(7'h7F, 4'hF, 64'h0123456789ABCDEF);
    for (int a = 0; a < 3; a++) begin
      if (a == 1) handshake(PID_ACK);
      else tick();
      repeat (5) tick();
      send_last(0, 1'b1);
      repeat (6) tick();
      send_last(0, 1'b0);
      if (a == 0) handshake(PID_DATA0);
      else tick();
      repeat (3) tick();
      if (a < 2) begin
        push_exp(1'b0, PID_OUT, 1'b0, '0, cyc + 1 + IPG_CYCLES);
        handshake(PID_NAK);
      end else begin
        push_exp(1'b1, 8'h00, 1'b0, 2'd2, cyc + 1);
        handshake(PID_ACK);
      end
    end
    drain(20);

    // Timeout on every attempt exhausts the retries.
    request(7'h11, 4'h1, 64'hFFFF0000AAAA5555);
    for (int a = 0; a < 3; a++) begin
      repeat (6) tick();
      send_last(0, 1'b1);
      repeat (6) tick();
      d = cyc;
      if (a < 2) push_exp(1'b0, PID_OUT, 1'b0, '0, d + TIMEOUT_CYCLES + 1 + IPG_CYCLES);
      else push_exp(1'b1, 8'h00, 1'b1, 2'd2, d + TIMEOUT_CYCLES + 1);
      send_last(0, 1'b0);
      if (a < 2) repeat (TIMEOUT_CYCLES + IPG_CYCLES) tick();
    end
    drain(40);

    // ACK arriving in the final WAIT_HS cycle still wins.
    request(7'h22, 4'h2, 64'h8000000000000001);
    repeat (6) tick();
    send_last(0, 1'b1);
    repeat (6) tick();
    send_last(0, 1'b0);
    repeat (TIMEOUT_CYCLES - 1) tick();
    push_exp(1'b1, 8'h00, 1'b0, 2'd0, cyc + 1);
    handshake(PID_ACK);
    drain(20);

    // Abort in WAIT_DATA, then stray tx_last/ACK, then a normal transaction.
    request(7'h33, 4'h6, 64'h1234567812345678);
    repeat (6) tick();
    send_last(0, 1'b1);
    repeat (6) tick();
    drain(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_addr", 64'(addr_out), 64'd0);
    check("abort_retries", 64'(retries), 64'd0);
    tx_last = 1'b1;
    tick();
    tx_last = 1'b0;
    handshake(PID_ACK);
    repeat (20) tick();
    check("abort_still_idle", 64'(req_ready), 64'd1);
    request(7'h44, 4'h9, 64'hA5A5A5A5A5A5A5A5);
    repeat (6) tick();
    send_last(0, 1'b1);
    repeat (6) tick();
    send_last(0, 1'b0);
    tick();
    push_exp(1'b1, 8'h00, 1'b0, 2'd0, cyc + 1);
    handshake(PID_ACK);
    drain(20);
    tick();
    check("final_idle", 64'(req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
